// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Instruction-fetch sequencer. Owns the PC, drives the synchronous
//            ROM address, tracks the one-cycle read latency and delivers
//            {pc, instr} to decode through a valid/ready handshake backed by
//            a 2-entry skid FIFO. Handles branch redirect, halt and
//            out-of-range fetch detection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int                 MEM_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fault
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  // One extra bit so MEM_WORDS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0]   fifo_pc_q [2];
  logic [ADDR_W-1:0]   fifo_pc_d [2];
  logic [INSTR_W-1:0]  fifo_instr_q [2];
  logic [INSTR_W-1:0]  fifo_instr_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                fault_q, fault_d;

  logic                pop;
  logic                pop_fifo;
  logic                push;
  logic                redirect;
  logic [2:0]          occupancy;
  logic                want_issue;
  logic                pc_oob;
  logic                do_issue;

  assign imem_addr = fetch_pc_q;
  assign fault     = fault_q;

  // Output select: FIFO head when buffered, otherwise bypass the returning ROM word.
  always_comb begin
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    if (count_q != 2'd0) begin
      if_valid = 1'b1;
      if_instr = fifo_instr_q[rd_ptr_q];
      if_pc    = fifo_pc_q[rd_ptr_q];
    end else if (inflight_q) begin
      if_valid = 1'b1;
      if_instr = imem_data;
      if_pc    = inflight_pc_q;
    end
  end

  // Next-state: issue decision, FIFO push/pop, redirect flush and FSM.
  always_comb begin
    pop        = if_valid && if_ready;
    pop_fifo   = pop && (count_q != 2'd0);
    redirect   = branch_valid && (state_q != ST_FAULT);
    // Slots that will be occupied after this edge if nothing new is issued.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    want_issue = (state_q == ST_RUN) && !halt && !redirect && (occupancy < 3'd2);
    pc_oob     = ({1'b0, fetch_pc_q} >= MEM_LIMIT);
    do_issue   = want_issue && !pc_oob;
    // A bypassed word that decode takes this cycle never needs a FIFO slot.
    push       = inflight_q && !redirect && !((count_q == 2'd0) && pop);

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fault_d       = fault_q;

    if (do_issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 1'b1;
    end

    if (push) begin
      fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
      fifo_instr_d[wr_ptr_q] = imem_data;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop_fifo) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop_fifo};

    case (state_q)
      ST_RUN: begin
        if (want_issue && pc_oob) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else if (halt && !branch_valid) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!halt || branch_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase

    // Redirect wins over everything: drop buffered and in-flight wrong-path words.
    if (redirect) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
      fetch_pc_d = branch_target;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fifo_pc_q     <= '{default: '0};
      fifo_instr_q  <= '{default: '0};
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fault_q       <= fault_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Directed self-checking bench for fetch_controller. A full-size
//            instance covers streaming, stall, redirect and halt; a 16-word
//            instance covers the out-of-range fault.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  logic        clk;
  // Main instance (256-word ROM)
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        fault;
  // Small instance (16-word ROM)
  logic        reset_f;
  logic [15:0] imem_addr_f;
  logic [15:0] imem_data_f;
  logic        branch_valid_f;
  logic [15:0] branch_target_f;
  logic        if_valid_f;
  logic [15:0] if_instr_f;
  logic [15:0] if_pc_f;
  logic        fault_f;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_controller #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt(halt),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fault(fault)
  );

  fetch_controller #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .MEM_WORDS(16)) dut_f (
    .clk(clk), .reset(reset_f), .imem_addr(imem_addr_f), .imem_data(imem_data_f),
    .branch_valid(branch_valid_f), .branch_target(branch_target_f), .halt(1'b0),
    .if_valid(if_valid_f), .if_ready(1'b1), .if_instr(if_instr_f), .if_pc(if_pc_f),
    .fault(fault_f)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM models: word i = 16'hA000 + i, one-cycle latency.
  always_ff @(posedge clk) begin
    imem_data   <= 16'hA000 + imem_addr;
    imem_data_f <= 16'hA000 + imem_addr_f;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; sampling happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; if_ready = 1'b1; branch_valid = 1'b0; branch_target = '0; halt = 1'b0;
    reset_f = 1'b1; branch_valid_f = 1'b0; branch_target_f = '0;
    repeat (3) tick();

    // Reset state
    check("rst_addr",  32'(imem_addr), 32'h0);
    check("rst_valid", 32'(if_valid),  32'h0);
    check("rst_instr", 32'(if_instr),  32'h0);
    check("rst_pc",    32'(if_pc),     32'h0);
    check("rst_fault", 32'(fault),     32'h0);

    // Cycle 1 after reset release: address driven, nothing valid yet
    reset = 1'b0;
    check("c1_valid", 32'(if_valid), 32'h0);
    check("c1_addr",  32'(imem_addr), 32'h0);
    tick();

    // Cycles 2..5: pcs 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      check("seq_valid", 32'(if_valid), 32'h1);
      check("seq_pc",    32'(if_pc),    i);
      check("seq_instr", 32'(if_instr), 32'hA000 + i);
      tick();
    end

    // Cycles 6..10: decode stalls on pc 4
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(if_valid), 32'h1);
      check("stall_pc",    32'(if_pc),    32'h4);
      check("stall_instr", 32'(if_instr), 32'hA004);
      if (k == 2) check("stall_count", 32'(dut.count_q), 32'h2);
      if (k == 3) check("stall_addr",  32'(imem_addr),   32'h6);
      tick();
    end

    // Cycles 11..16: resume with pcs 4..9, no gap or repeat
    if_ready = 1'b1;
    for (int i = 4; i <= 9; i++) begin
      check("resume_valid", 32'(if_valid), 32'h1);
      check("resume_pc",    32'(if_pc),    i);
      check("resume_instr", 32'(if_instr), 32'hA000 + i);
      tick();
    end

    // Cycle 17: pc 10 at head, pc 11 in flight; redirect to 0x40 without accepting
    check("br_head_pc", 32'(if_pc), 32'hA);
    if_ready = 1'b0; branch_valid = 1'b1; branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0; if_ready = 1'b1;
    // Cycle 18: bubble, ROM addressed at target
    check("br_gap_valid", 32'(if_valid),  32'h0);
    check("br_addr",      32'(imem_addr), 32'h40);
    tick();
    // Cycle 19/20: target, target+1
    check("br_tgt_valid", 32'(if_valid), 32'h1);
    check("br_tgt_pc",    32'(if_pc),    32'h40);
    check("br_tgt_instr", 32'(if_instr), 32'hA040);
    tick();
    check("br_tgt1_pc",   32'(if_pc),    32'h41);
    tick();

    // Cycle 21: branch together with an accepted head (pc 0x42)
    check("brh_head_pc", 32'(if_pc), 32'h42);
    branch_valid = 1'b1; branch_target = 16'h0080;
    tick();
    branch_valid = 1'b0;
    check("brh_gap_valid", 32'(if_valid), 32'h0);
    tick();
    check("brh_tgt_pc",    32'(if_pc),    32'h80);
    check("brh_tgt_valid", 32'(if_valid), 32'h1);
    tick();

    // Cycle 24: halt rises; pc 0x81 (already in flight) is still delivered
    check("halt_last_pc", 32'(if_pc),    32'h81);
    check("halt_last_v",  32'(if_valid), 32'h1);
    halt = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("halt_valid", 32'(if_valid),  32'h0);
      check("halt_addr",  32'(imem_addr), 32'h82);
      tick();
    end
    // Cycle 30: halt drops; resume at 0x82 two cycles later
    halt = 1'b0;
    check("unhalt_v0", 32'(if_valid), 32'h0);
    tick();
    check("unhalt_v1", 32'(if_valid), 32'h0);
    tick();
    check("unhalt_pc", 32'(if_pc), 32'h82);
    check("unhalt_v2", 32'(if_valid), 32'h1);
    tick();

    // Cycle 33: halt again, then branch while halted
    check("hb_pc", 32'(if_pc), 32'h83);
    halt = 1'b1;
    tick();
    check("hb_valid", 32'(if_valid), 32'h0);
    branch_valid = 1'b1; branch_target = 16'h0020;
    tick();
    branch_valid = 1'b0; halt = 1'b0;
    check("hb_addr", 32'(imem_addr), 32'h20);
    tick();
    check("hb_tgt_pc",    32'(if_pc),    32'h20);
    check("hb_tgt_valid", 32'(if_valid), 32'h1);

    // Fault instance: run past the last legal word (15)
    reset_f = 1'b0;
    check("f_c1_valid", 32'(if_valid_f), 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check("f_seq_pc",    32'(if_pc_f),    i);
      check("f_seq_instr", 32'(if_instr_f), 32'hA000 + i);
      if (i == 15) check("f_fault_early", 32'(fault_f), 32'h0);
      tick();
    end
    check("f_valid_after", 32'(if_valid_f), 32'h0);
    check("f_fault_rise",  32'(fault_f),    32'h1);
    branch_valid_f = 1'b1; branch_target_f = 16'h0000;
    tick();
    branch_valid_f = 1'b0;
    check("f_br_ignored_addr", 32'(imem_addr_f), 32'h10);
    check("f_br_ignored_v",    32'(if_valid_f),  32'h0);
    check("f_fault_sticky",    32'(fault_f),     32'h1);
    tick();
    check("f_valid_later", 32'(if_valid_f), 32'h0);
    check("f_fault_later", 32'(fault_f),    32'h1);
    reset_f = 1'b1;
    tick();
    check("f_rst_fault", 32'(fault_f),     32'h0);
    check("f_rst_addr",  32'(imem_addr_f), 32'h0);
    check("f_rst_valid", 32'(if_valid_f),  32'h0);
    reset_f = 1'b0;
    tick();
    check("f_restart_pc",    32'(if_pc_f),    32'h0);
    check("f_restart_instr", 32'(if_instr_f), 32'hA000);
    check("f_restart_valid", 32'(if_valid_f), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
